// File: rtl/usrp2puf.sv
// usrp2puf: 5:4 fractional-rate decimator from the USRP sample rate to the PUF sample rate.
// Every 5 accepted input samples yield 4 output samples at input-time positions 0, 1.25, 2.5 and
// 3.75, formed by linear interpolation between neighbouring samples. I and Q are independent.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   in_tdata     {I, Q} input sample, two's complement, I in the upper half
//   in_tvalid    input beat valid
//   in_tlast     last input beat of a packet (forces an output beat and restarts the phase)
//   in_tready    input accepted when in_tvalid & in_tready
//   out_tdata    {I, Q} output sample
//   out_tvalid   output beat valid
//   out_tlast    last output beat of a packet
//   out_tready   downstream ready
module usrp2puf #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*DATA_WIDTH-1:0] in_tdata,
  input  logic                    in_tvalid,
  input  logic                    in_tlast,
  output logic                    in_tready,
  output logic [2*DATA_WIDTH-1:0] out_tdata,
  output logic                    out_tvalid,
  output logic                    out_tlast,
  input  logic                    out_tready
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned ExtW = DATA_WIDTH + 3;

  logic [2:0]      phase_q;
  logic [2*W-1:0]  prev_q;
  logic            accept;
  logic            emit;
  logic [2*W-1:0]  result;

  // Weighted sum (weights from the phase) plus rounding constant, then >>> 2. Two's-complement
  // addition is sign-agnostic, and an arithmetic shift truncated back to W bits is just the bit
  // slice [W+1:2], so the whole thing can be done on plain sign-extended vectors.
  function automatic logic [W-1:0] interp(input logic [W-1:0] p, input logic [W-1:0] c,
                                          input logic [2:0] ph);
    logic [ExtW-1:0] pe;
    logic [ExtW-1:0] ce;
    logic [ExtW-1:0] sum;
    pe = {{3{p[W-1]}}, p};
    ce = {{3{c[W-1]}}, c};
    case (ph)
      3'd2:    sum = (pe << 1) + pe + ce + ExtW'(2);
      3'd3:    sum = (pe << 1) + (ce << 1) + ExtW'(2);
      default: sum = pe + (ce << 1) + ce + ExtW'(2);
    endcase
    return sum[W+1:2];
  endfunction

  assign in_tready = ~reset & (~out_tvalid | out_tready);
  assign accept    = in_tvalid & in_tready;
  // Phase 1 produces nothing unless it closes a packet.
  assign emit      = accept & ((phase_q != 3'd1) | in_tlast);

  always_comb begin
    result = in_tdata;
    if (phase_q >= 3'd2) begin
      result = {interp(prev_q[2*W-1:W], in_tdata[2*W-1:W], phase_q),
                interp(prev_q[W-1:0],   in_tdata[W-1:0],   phase_q)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= 3'd0;
      prev_q     <= '0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else begin
      if (out_tready) begin
        out_tvalid <= 1'b0;
      end
      if (accept) begin
        prev_q  <= in_tdata;
        phase_q <= (in_tlast || phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
        if (emit) begin
          out_tvalid <= 1'b1;
          out_tdata  <= result;
          out_tlast  <= in_tlast;
        end
      end
    end
  end

endmodule

// File: tb/tb_usrp2puf.sv
// Self-checking bench for usrp2puf. The reference model works in terms of output time positions
// (output m of a group sits at input time 1.25*m) rather than the DUT's per-phase arithmetic.
module tb_usrp2puf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_tdata;
  logic        in_tvalid;
  logic        in_tlast;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tlast;
  logic        out_tready;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          ready_mode = 0;  // 0: always 1, 1: toggle, 2: random, 3: held low
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  logic        held = 1'b0;
  logic [32:0] held_val;

  always #5 clk = ~clk;

  usrp2puf #(.DATA_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_tdata  (in_tdata),
    .in_tvalid (in_tvalid),
    .in_tlast  (in_tlast),
    .in_tready (in_tready),
    .out_tdata (out_tdata),
    .out_tvalid(out_tvalid),
    .out_tlast (out_tlast),
    .out_tready(out_tready)
  );

  initial begin
    out_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_tready = 1'b1;
        1:       out_tready = ~out_tready;
        2:       out_tready = 1'($urandom_range(0, 1));
        default: out_tready = 1'b0;
      endcase
    end
  end

  // Output monitor and stall-stability check, sampled mid-cycle.
  always @(negedge clk) begin
    if (held && !reset) begin
      n_cmp++;
      if ({out_tvalid, out_tlast, out_tdata} !== {1'b1, held_val}) begin
        n_fail++;
        $display("FAIL stall_stable got v=%b %h want v=1 %h", out_tvalid,
                 {out_tlast, out_tdata}, held_val);
      end
    end
    if (!reset && out_tvalid && out_tready) got_q.push_back({out_tlast, out_tdata});
    held     = out_tvalid && !out_tready && !reset;
    held_val = {out_tlast, out_tdata};
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pk(input int i, input int q);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'(i);
    b = 16'(q);
    return {a, b};
  endfunction

  function automatic int interp(input int a, input int b, input int frac);
    int v;
    v = (4 - frac) * a + frac * b + 2;
    return v >>> 2;
  endfunction

  // Output m of each 5-sample group lies at quarter-position 5*m; it needs samples up to
  // ceil of that position. A packet ending on group offset 1 flushes that sample unchanged.
  function automatic void model(input logic [31:0] s[$], input bit term);
    int n;
    n = s.size();
    for (int base = 0; base < n; base += 5) begin
      for (int m = 0; m < 4; m++) begin
        int pos;
        int idx;
        int frac;
        int need;
        logic [15:0] vi;
        logic [15:0] vq;
        pos  = 5 * m;
        idx  = base + pos / 4;
        frac = pos % 4;
        need = idx + ((frac != 0) ? 1 : 0);
        if (need <= n - 1) begin
          vi = 16'(interp(int'($signed(s[idx][31:16])), int'($signed(s[need][31:16])), frac));
          vq = 16'(interp(int'($signed(s[idx][15:0])), int'($signed(s[need][15:0])), frac));
          exp_q.push_back({term && (need == n - 1), vi, vq});
        end
      end
    end
    if (term && ((n - 1) % 5 == 1)) exp_q.push_back({1'b1, s[n-1]});
  endfunction

  task automatic send(input logic [31:0] s[$], input bit term, input int gap_pct);
    for (int i = 0; i < s.size(); i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        in_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_tvalid = 1'b1;
      in_tdata  = s[i];
      in_tlast  = term && (i == s.size() - 1);
      begin
        int t;
        bit acc;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 100) begin
          @(negedge clk);
          acc = in_tready;
          @(posedge clk);
          #1;
          t++;
        end
        if (!acc) begin
          n_cmp++;
          n_fail++;
          $display("FAIL send_timeout got no handshake want accept of beat %0d", i);
        end
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((got_q.size() < exp_q.size() || out_tvalid) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    ready_mode = 0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tready got %b want 0", in_tready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_tvalid, out_tlast, out_tdata} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b %b %h want 0 0 0", out_tvalid, out_tlast, out_tdata);
    end
    n_cmp++;
    if (in_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_tready got %b want 1", in_tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    logic [31:0] s[$];
    do_reset();
    ready_mode = 0;
    for (int k = 0; k < 6; k++) s.push_back(pk(4 * k, -4 * k));
    model(s, 1'b0);
    send(s, 1'b0, 0);
    wait_drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL ramp_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ramp[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() > 4) begin
      n_cmp++;
      if (got_q[1] !== {1'b0, 16'd5, 16'hFFFB} || got_q[4] !== {1'b0, 16'd20, 16'hFFEC}) begin
        n_fail++;
        $display("FAIL ramp_literal got %h %h want 00005fffb 00014ffec", got_q[1], got_q[4]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [31:0] a[$];
    logic [31:0] b[$];
    logic [31:0] c[$];
    logic [31:0] d[$];
    do_reset();
    ready_mode = 0;
    a = '{pk(7, 7), pk(-1, -1), pk(0, 0)};
    b = '{pk(0, 0), pk(0, 0), pk(-1, -1), pk(0, 0)};
    for (int k = 0; k < 5; k++) c.push_back(pk(-32768, -32768));
    for (int k = 0; k < 5; k++) d.push_back(pk(32767, 32767));
    model(a, 1'b1);
    model(b, 1'b1);
    model(c, 1'b1);
    model(d, 1'b1);
    send(a, 1'b1, 0);
    send(b, 1'b1, 0);
    send(c, 1'b1, 0);
    send(d, 1'b1, 0);
    wait_drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL extremes_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL extremes[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() > 4) begin
      n_cmp++;
      if (got_q[1] !== {1'b1, 32'hFFFF_FFFF} || got_q[4] !== {1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL round_literal got %h %h want 1ffffffff 100000000", got_q[1], got_q[4]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s[$];
    do_reset();
    ready_mode = 1;
    for (int k = 0; k < 20; k++) s.push_back($urandom);
    model(s, 1'b0);
    send(s, 1'b0, 0);
    ready_mode = 0;
    wait_drain();
    n_cmp++;
    if (got_q.size() !== 16) begin
      n_fail++;
      $display("FAIL bp_count got %0d want 16", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_tlast_phase1();
    logic [31:0] s[$];
    logic [31:0] s2[$];
    do_reset();
    ready_mode = 0;
    for (int k = 0; k < 7; k++) s.push_back($urandom);
    s2.push_back($urandom);
    model(s, 1'b1);
    model(s2, 1'b0);
    send(s, 1'b1, 20);
    send(s2, 1'b0, 0);
    wait_drain();
    n_cmp++;
    if (got_q.size() !== 7) begin
      n_fail++;
      $display("FAIL tlast1_count got %0d want 7", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL tlast1[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() > 6) begin
      n_cmp++;
      if (got_q[5] !== {1'b1, s[6]} || got_q[6] !== {1'b0, s2[0]}) begin
        n_fail++;
        $display("FAIL tlast1_pass got %h %h want %h %h", got_q[5], got_q[6], {1'b1, s[6]},
                 {1'b0, s2[0]});
      end
    end
  endtask

  task automatic test_tlast_phase3();
    logic [31:0] s[$];
    logic [31:0] s2[$];
    do_reset();
    ready_mode = 0;
    s  = '{pk(0, 0), pk(4, -4), pk(8, -8), pk(12, -12)};
    s2 = '{pk(7, -9)};
    model(s, 1'b1);
    model(s2, 1'b0);
    send(s, 1'b1, 0);
    send(s2, 1'b0, 0);
    wait_drain();
    n_cmp++;
    if (got_q.size() !== 4) begin
      n_fail++;
      $display("FAIL tlast3_count got %0d want 4", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL tlast3[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() > 3) begin
      n_cmp++;
      if (got_q[2] !== {1'b1, 16'd10, 16'hFFF6} || got_q[3] !== {1'b0, pk(7, -9)}) begin
        n_fail++;
        $display("FAIL tlast3_literal got %h %h want 1000afff6 %h", got_q[2], got_q[3],
                 {1'b0, pk(7, -9)});
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [31:0] s[$];
    do_reset();
    ready_mode = 0;
    s = '{pk(0, 0), pk(4, -4)};
    send(s, 1'b0, 0);
    ready_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    s = '{pk(8, -8)};
    send(s, 1'b0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_held got %b want 1", out_tvalid);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_drop got %b want 0", out_tvalid);
    end
    got_q.delete();
    ready_mode = 0;
    @(posedge clk);
    #1;
    s = '{pk(100, -100)};
    send(s, 1'b0, 0);
    wait_drain();
    n_cmp++;
    if (got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL midreset_count got %0d want 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== {1'b0, pk(100, -100)}) begin
        n_fail++;
        $display("FAIL midreset_first got %h want %h", got_q[0], {1'b0, pk(100, -100)});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    ready_mode = 2;
    for (int p = 0; p < 8; p++) begin
      logic [31:0] s[$];
      int len;
      len = int'($urandom_range(1, 13));
      for (int k = 0; k < len; k++) s.push_back($urandom);
      model(s, 1'b1);
      send(s, 1'b1, 30);
    end
    wait_drain();
    ready_mode = 0;
    wait_drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_tdata  = '0;
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    test_reset();
    test_ramp();
    test_extremes();
    test_backpressure();
    test_tlast_phase1();
    test_tlast_phase3();
    test_reset_mid_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
